// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings used by decoder/RS/ALU, and the queued result entry.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_IDX_W = 5;
    localparam int OP_W      = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OP_W-1:0] OP_AND   = 6'd3;
    localparam logic [OP_W-1:0] OP_OR    = 6'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd5;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd6;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd7;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd8;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd9;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd11;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd15;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd16;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd17;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd18;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd19;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd20;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd21;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd22;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd23;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd24;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd25;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd26;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd27;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd28;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd29;

    typedef struct packed {
        logic [DATA_W-1:0]    value;
        logic [ROB_IDX_W-1:0] rob_tag;
        logic                 is_branch;
        logic                 taken;
        logic [DATA_W-1:0]    target;
    } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous FIFO with flush; head is combinational, write-to-head latency 1 cycle.
// No internal overflow guard: caller pushes only when count<DEPTH or popping in the same cycle.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: evaluates the issued op and queues it for CDB broadcast one cycle later.
// Backpressure: registered alu_full asserts one entry early; a push into a full buffer is dropped and flagged.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int ROB_IDX_W  = alu_pkg::ROB_IDX_W,
    parameter int OP_W       = alu_pkg::OP_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 jump_wrong,
    input  logic                 alu_enable,
    input  logic [OP_W-1:0]      to_alu_op,
    input  logic [DATA_W-1:0]    to_alu_rs1_value,
    input  logic [DATA_W-1:0]    to_alu_rs2_value,
    input  logic [DATA_W-1:0]    to_alu_imm,
    input  logic [DATA_W-1:0]    to_alu_pc,
    input  logic [ROB_IDX_W-1:0] to_alu_rd_renaming,
    input  logic                 cdb_grant,
    output logic                 alu_broadcast,
    output logic [DATA_W-1:0]    alu_cbd_value,
    output logic [ROB_IDX_W-1:0] alu_update_rename,
    output logic                 alu_is_branch,
    output logic                 alu_branch_taken,
    output logic [DATA_W-1:0]    alu_branch_target,
    output logic                 alu_full,
    output logic                 alu_overflow_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic alu_result_t execute(
        input logic [OP_W-1:0]      op,
        input logic [DATA_W-1:0]    a,
        input logic [DATA_W-1:0]    b,
        input logic [DATA_W-1:0]    imm,
        input logic [DATA_W-1:0]    pc,
        input logic [ROB_IDX_W-1:0] tag
    );
        alu_result_t       r;
        logic [DATA_W-1:0] seq_pc;
        logic [DATA_W-1:0] rel_tgt;
        logic              cond;
        r         = '0;
        r.rob_tag = tag;
        seq_pc    = pc + DATA_W'(4);
        rel_tgt   = pc + imm;
        cond      = 1'b0;
        case (op)
            OP_ADD:   r.value = a + b;
            OP_SUB:   r.value = a - b;
            OP_AND:   r.value = a & b;
            OP_OR:    r.value = a | b;
            OP_XOR:   r.value = a ^ b;
            OP_SLT:   r.value = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  r.value = {{(DATA_W-1){1'b0}}, a < b};
            OP_SLL:   r.value = a << b[4:0];
            OP_SRL:   r.value = a >> b[4:0];
            OP_SRA:   r.value = $signed(a) >>> b[4:0];
            OP_ADDI:  r.value = a + imm;
            OP_ANDI:  r.value = a & imm;
            OP_ORI:   r.value = a | imm;
            OP_XORI:  r.value = a ^ imm;
            OP_SLTI:  r.value = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(imm)};
            OP_SLTIU: r.value = {{(DATA_W-1){1'b0}}, a < imm};
            OP_SLLI:  r.value = a << imm[4:0];
            OP_SRLI:  r.value = a >> imm[4:0];
            OP_SRAI:  r.value = $signed(a) >>> imm[4:0];
            OP_LUI:   r.value = imm;
            OP_AUIPC: r.value = rel_tgt;
            OP_JAL: begin
                r.value     = seq_pc;
                r.is_branch = 1'b1;
                r.taken     = 1'b1;
                r.target    = rel_tgt;
            end
            OP_JALR: begin
                r.value     = seq_pc;
                r.is_branch = 1'b1;
                r.taken     = 1'b1;
                r.target    = (a + imm) & ~DATA_W'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  cond = (a == b);
                    OP_BNE:  cond = (a != b);
                    OP_BLT:  cond = ($signed(a) < $signed(b));
                    OP_BGE:  cond = ($signed(a) >= $signed(b));
                    OP_BLTU: cond = (a < b);
                    default: cond = (a >= b);
                endcase
                r.is_branch = 1'b1;
                r.taken     = cond;
                r.target    = cond ? rel_tgt : seq_pc;
            end
            default: r.value = '0;
        endcase
        return r;
    endfunction

    alu_result_t    issue_res;
    alu_result_t    head;
    logic [CW-1:0]  count;
    logic [CW-1:0]  next_count;
    logic           push_req;
    logic           push;
    logic           pop;
    logic           at_cap;

    assign issue_res = execute(to_alu_op, to_alu_rs1_value, to_alu_rs2_value,
                               to_alu_imm, to_alu_pc, to_alu_rd_renaming);

    // A same-cycle pop frees the slot, so a full buffer can still accept.
    assign at_cap   = (count == CW'(FIFO_DEPTH));
    assign push_req = rdy && alu_enable && !jump_wrong;
    assign pop      = rdy && (count != '0) && cdb_grant;
    assign push     = push_req && (!at_cap || pop);

    always_comb begin
        next_count = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        if (jump_wrong) next_count = '0;
    end

    alu_result_fifo #(
        .WIDTH ($bits(alu_result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (issue_res),
        .pop       (pop),
        .flush     (jump_wrong),
        .head_data (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full         <= 1'b0;
            alu_overflow_err <= 1'b0;
        end else begin
            alu_full <= (next_count >= CW'(FIFO_DEPTH - 1));
            if (push_req && at_cap && !pop) alu_overflow_err <= 1'b1;
        end
    end

    assign alu_broadcast     = (count != '0);
    assign alu_cbd_value     = alu_broadcast ? head.value     : '0;
    assign alu_update_rename = alu_broadcast ? head.rob_tag   : '0;
    assign alu_is_branch     = alu_broadcast ? head.is_branch : 1'b0;
    assign alu_branch_taken  = alu_broadcast ? head.taken     : 1'b0;
    assign alu_branch_target = alu_broadcast ? head.target    : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rdy;
    logic                 jump_wrong;
    logic                 alu_enable;
    logic [OP_W-1:0]      to_alu_op;
    logic [DATA_W-1:0]    to_alu_rs1_value;
    logic [DATA_W-1:0]    to_alu_rs2_value;
    logic [DATA_W-1:0]    to_alu_imm;
    logic [DATA_W-1:0]    to_alu_pc;
    logic [ROB_IDX_W-1:0] to_alu_rd_renaming;
    logic                 cdb_grant;
    logic                 alu_broadcast;
    logic [DATA_W-1:0]    alu_cbd_value;
    logic [ROB_IDX_W-1:0] alu_update_rename;
    logic                 alu_is_branch;
    logic                 alu_branch_taken;
    logic [DATA_W-1:0]    alu_branch_target;
    logic                 alu_full;
    logic                 alu_overflow_err;

    int vectors = 0;
    int miscompares = 0;

    alu_exec_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .jump_wrong         (jump_wrong),
        .alu_enable         (alu_enable),
        .to_alu_op          (to_alu_op),
        .to_alu_rs1_value   (to_alu_rs1_value),
        .to_alu_rs2_value   (to_alu_rs2_value),
        .to_alu_imm         (to_alu_imm),
        .to_alu_pc          (to_alu_pc),
        .to_alu_rd_renaming (to_alu_rd_renaming),
        .cdb_grant          (cdb_grant),
        .alu_broadcast      (alu_broadcast),
        .alu_cbd_value      (alu_cbd_value),
        .alu_update_rename  (alu_update_rename),
        .alu_is_branch      (alu_is_branch),
        .alu_branch_taken   (alu_branch_taken),
        .alu_branch_target  (alu_branch_target),
        .alu_full           (alu_full),
        .alu_overflow_err   (alu_overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        to_alu_op          = op;
        to_alu_rs1_value   = a;
        to_alu_rs2_value   = b;
        to_alu_imm         = imm;
        to_alu_pc          = pc;
        to_alu_rd_renaming = tag;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        set_op(op, a, b, imm, pc, tag);
        alu_enable = 1'b1;
        step();
        alu_enable = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".bcast"},  {31'd0, alu_broadcast},     32'd0);
        chk({name, ".value"},  alu_cbd_value,              32'd0);
        chk({name, ".tag"},    {27'd0, alu_update_rename}, 32'd0);
        chk({name, ".isbr"},   {31'd0, alu_is_branch},     32'd0);
        chk({name, ".taken"},  {31'd0, alu_branch_taken},  32'd0);
        chk({name, ".target"}, alu_branch_target,          32'd0);
        chk({name, ".full"},   {31'd0, alu_full},          32'd0);
        chk({name, ".ovf"},    {31'd0, alu_overflow_err},  32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; alu_enable = 1'b0; cdb_grant = 1'b0;
        set_op(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #2;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // ADD wraps; one-cycle latency, then popped by the grant
        cdb_grant = 1'b1;
        issue(OP_ADD, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd3);
        chk("add.bcast", {31'd0, alu_broadcast}, 32'd1);
        chk("add.value", alu_cbd_value, 32'd6);
        chk("add.tag", {27'd0, alu_update_rename}, 32'd3);
        chk("add.isbr", {31'd0, alu_is_branch}, 32'd0);
        step();
        chk("add.drained", {31'd0, alu_broadcast}, 32'd0);

        // SRAI then SLTU, presented in issue order
        cdb_grant = 1'b0;
        issue(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd4);
        issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd5);
        chk("srai.value", alu_cbd_value, 32'hF800_0000);
        chk("srai.tag", {27'd0, alu_update_rename}, 32'd4);
        cdb_grant = 1'b1;
        step();
        chk("sltu.value", alu_cbd_value, 32'd1);
        chk("sltu.tag", {27'd0, alu_update_rename}, 32'd5);
        step();
        chk("sltu.drained", {31'd0, alu_broadcast}, 32'd0);

        // BNE not taken, then JALR with low target bit cleared
        cdb_grant = 1'b0;
        issue(OP_BNE, 32'd5, 32'd5, 32'h20, 32'h100, 5'd6);
        issue(OP_JALR, 32'h203, 32'd0, 32'd2, 32'h40, 5'd7);
        chk("bne.value", alu_cbd_value, 32'd0);
        chk("bne.isbr", {31'd0, alu_is_branch}, 32'd1);
        chk("bne.taken", {31'd0, alu_branch_taken}, 32'd0);
        chk("bne.target", alu_branch_target, 32'h104);
        cdb_grant = 1'b1;
        step();
        chk("jalr.value", alu_cbd_value, 32'h44);
        chk("jalr.isbr", {31'd0, alu_is_branch}, 32'd1);
        chk("jalr.taken", {31'd0, alu_branch_taken}, 32'd1);
        chk("jalr.target", alu_branch_target, 32'h204);
        step();
        chk("jalr.drained", {31'd0, alu_broadcast}, 32'd0);

        // Fill to capacity, drop a fifth issue, then drain in order
        cdb_grant = 1'b0;
        issue(OP_ADDI, 32'h00, 32'd0, 32'd1, 32'd0, 5'd8);
        chk("fill1.full", {31'd0, alu_full}, 32'd0);
        issue(OP_ADDI, 32'h10, 32'd0, 32'd1, 32'd0, 5'd9);
        chk("fill2.full", {31'd0, alu_full}, 32'd0);
        issue(OP_ADDI, 32'h20, 32'd0, 32'd1, 32'd0, 5'd10);
        chk("fill3.full", {31'd0, alu_full}, 32'd1);
        issue(OP_ADDI, 32'h30, 32'd0, 32'd1, 32'd0, 5'd11);
        chk("fill4.full", {31'd0, alu_full}, 32'd1);
        chk("fill4.ovf", {31'd0, alu_overflow_err}, 32'd0);
        issue(OP_ADDI, 32'h40, 32'd0, 32'd1, 32'd0, 5'd12);
        chk("fill5.ovf", {31'd0, alu_overflow_err}, 32'd1);
        chk("drain0.value", alu_cbd_value, 32'h01);
        cdb_grant = 1'b1;
        step();
        chk("drain1.value", alu_cbd_value, 32'h11);
        chk("drain1.full", {31'd0, alu_full}, 32'd1);
        step();
        chk("drain2.value", alu_cbd_value, 32'h21);
        chk("drain2.full", {31'd0, alu_full}, 32'd0);
        step();
        chk("drain3.value", alu_cbd_value, 32'h31);
        chk("drain3.tag", {27'd0, alu_update_rename}, 32'd11);
        step();
        chk("drain4.bcast", {31'd0, alu_broadcast}, 32'd0);
        chk("drain4.ovf", {31'd0, alu_overflow_err}, 32'd1);

        // Unknown op still broadcasts; flush with a simultaneous issue
        cdb_grant = 1'b0;
        issue(6'h3F, 32'h1234, 32'h5678, 32'h9, 32'h80, 5'd13);
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd14);
        chk("unk.bcast", {31'd0, alu_broadcast}, 32'd1);
        chk("unk.value", alu_cbd_value, 32'd0);
        chk("unk.isbr", {31'd0, alu_is_branch}, 32'd0);
        chk("unk.tag", {27'd0, alu_update_rename}, 32'd13);
        set_op(OP_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'd0, 5'd15);
        alu_enable = 1'b1;
        jump_wrong = 1'b1;
        step();
        alu_enable = 1'b0;
        jump_wrong = 1'b0;
        chk("flush.bcast", {31'd0, alu_broadcast}, 32'd0);
        chk("flush.full", {31'd0, alu_full}, 32'd0);
        chk("flush.ovf", {31'd0, alu_overflow_err}, 32'd1);
        cdb_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush.quiet", {31'd0, alu_broadcast}, 32'd0);
        end

        // rdy low freezes the head and ignores issue
        cdb_grant = 1'b0;
        issue(OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd9);
        chk("auipc.value", alu_cbd_value, 32'h3000);
        rdy = 1'b0;
        cdb_grant = 1'b1;
        set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd2);
        alu_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz.bcast", {31'd0, alu_broadcast}, 32'd1);
            chk("frz.value", alu_cbd_value, 32'h3000);
            chk("frz.tag", {27'd0, alu_update_rename}, 32'd9);
        end
        alu_enable = 1'b0;
        rdy = 1'b1;
        step();
        chk("thaw.drained", {31'd0, alu_broadcast}, 32'd0);

        // Asynchronous reset mid-cycle with a valid head
        cdb_grant = 1'b0;
        issue(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd1);
        chk("lui.value", alu_cbd_value, 32'h1234_5000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
